// File: rtl/mips_mem_pkg.sv
// Shared encodings and op classification for the load/store unit.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        LSU_LW  = 3'b000,
        LSU_LH  = 3'b001,
        LSU_LHU = 3'b010,
        LSU_LB  = 3'b011,
        LSU_LBU = 3'b100,
        LSU_SW  = 3'b101,
        LSU_SH  = 3'b110,
        LSU_SB  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic logic is_sub(input lsu_op_e op);
        return (op == LSU_SH) || (op == LSU_SB);
    endfunction

    function automatic logic is_signed(input lsu_op_e op);
        return (op == LSU_LH) || (op == LSU_LB);
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
        case (op)
            LSU_LW, LSU_SW:          return off != 2'b00;
            LSU_LH, LSU_LHU, LSU_SH: return off[0];
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane extract (load extend) and merge (sub-word store) for a 32-bit word.
module lsu_byte_lane
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_buf_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  lsu_op_e     i_op,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant byte.
    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_off)
            2'd0: w_byte = i_load_word[31:24];
            2'd1: w_byte = i_load_word[23:16];
            2'd2: w_byte = i_load_word[15:8];
            2'd3: w_byte = i_load_word[7:0];
            default: w_byte = i_load_word[7:0];
        endcase
        w_half = i_off[1] ? i_load_word[15:0] : i_load_word[31:16];
    end

    always_comb begin
        o_extract = 32'h0;
        case (i_op)
            LSU_LW:  o_extract = i_load_word;
            LSU_LH:  o_extract = {{16{w_half[15]}}, w_half};
            LSU_LHU: o_extract = {16'h0, w_half};
            LSU_LB:  o_extract = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: o_extract = {24'h0, w_byte};
            default: o_extract = 32'h0;
        endcase
    end

    always_comb begin
        o_merge = i_wdata;
        if (i_op == LSU_SH) begin
            o_merge = i_off[1] ? {i_buf_word[31:16], i_wdata[15:0]}
                               : {i_wdata[15:0], i_buf_word[15:0]};
        end else if (i_op == LSU_SB) begin
            o_merge = i_buf_word;
            case (i_off)
                2'd0: o_merge[31:24] = i_wdata[7:0];
                2'd1: o_merge[23:16] = i_wdata[7:0];
                2'd2: o_merge[15:8]  = i_wdata[7:0];
                2'd3: o_merge[7:0]   = i_wdata[7:0];
                default: o_merge = i_buf_word;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-wide, byte-enable-less data memory.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip memory and respond with o_resp_err.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int addresswidth = 32,
    parameter int width        = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [2:0]              i_req_op,
    input  logic [addresswidth-1:0] i_req_addr,
    input  logic [width-1:0]        i_req_wdata,
    output logic                    o_resp_valid,
    output logic [width-1:0]        o_resp_rdata,
    output logic                    o_resp_err,
    output logic [addresswidth-1:0] o_mem_address,
    output logic                    o_mem_read_en,
    output logic                    o_mem_write_en,
    output logic [width-1:0]        o_mem_wdata,
    input  logic [width-1:0]        i_mem_rdata
);

    lsu_state_e              r_state, w_next;
    lsu_op_e                 r_op;
    logic [addresswidth-1:0] r_addr;
    logic [width-1:0]        r_wdata, r_buf, r_rdata;
    logic [width-1:0]        w_extract, w_merge;
    logic                    w_accept, w_misalign;

    assign w_accept = i_req_valid & o_req_ready;

`ifdef MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = is_misaligned(lsu_op_e'(i_req_op), i_req_addr[1:0]);
    assign o_resp_err = r_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)       r_err <= 1'b0;
        else if (w_accept) r_err <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
    assign o_resp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_misalign)                                         w_next = RESP;
                else if (lsu_op_e'(i_req_op) == LSU_SW)                 w_next = WR;
                else                                                    w_next = RD;
            end
            RD:   w_next = is_sub(r_op) ? WR : RESP;
            WR:   w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op    <= LSU_LW;
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= lsu_op_e'(i_req_op);
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end
            if (r_state == RD && is_sub(r_op))
                r_buf <= i_mem_rdata;
            // Response data only changes as resp_valid rises, so it holds between responses.
            if (w_next == RESP)
                r_rdata <= (r_state == RD && !is_store(r_op)) ? w_extract : '0;
        end
    end

    lsu_byte_lane u_lane (
        .i_load_word (i_mem_rdata),
        .i_buf_word  (r_buf),
        .i_wdata     (r_wdata),
        .i_off       (r_addr[1:0]),
        .i_op        (r_op),
        .o_extract   (w_extract),
        .o_merge     (w_merge)
    );

    assign o_req_ready    = (r_state == IDLE);
    assign o_resp_valid   = (r_state == RESP);
    assign o_mem_read_en  = (r_state == RD);
    assign o_mem_write_en = (r_state == WR);
    assign o_mem_address  = {r_addr[addresswidth-1:2], 2'b00};
    assign o_mem_wdata    = is_sub(r_op) ? w_merge : r_wdata;
    assign o_resp_rdata   = r_rdata;

endmodule
